vt100_report_encoder: RTL and testbench
=======================================

# vt100_report_encoder

Host-bound half of the VT100 terminal: turns local key events and terminal status reports into VT100 byte sequences for the UART transmitter. It is the reply path for the escape-sequence parser.
- The parser raises `reqCpr` on DSR 6 (ESC [ 6 n) and `reqDa` on DA (ESC [ c).
- The encoder serializes the answer, then any keystroke, one byte per valid/ready transfer.
- It sits between the keyboard front end, the parser's cursor registers and the UART TX.

## Interface
Parameters:
- ENABLE_DA, 1, when 0 `reqDa` is ignored and never latched.
- DA_OPTION, 0, option digit 0..9 in the DA reply (ESC [ ? 1 ; `DA_OPTION` c).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- keyValid  in  1  key event offered.
- keyCode  in  8  key code, see Operation.
- keyReady  out  1  key accepted when `keyValid && keyReady`.
- reqCpr  in  1  one-cycle pulse: cursor position report requested.
- reqDa  in  1  one-cycle pulse: device attributes requested.
- cursor_x  in  8  cursor row, 0-based.
- cursor_y  in  8  cursor column, 0-based.
- txData  out  8  byte to the UART.
- txValid  out  1  txData valid.
- txReady  in  1  UART accepts; transfer when `txValid && txReady`.
- busy  out  1  sequence in progress or request pending.

## Operation
Key codes:
- 0x00–0x7F: sent as the single byte itself.
- 0x80 Up / 0x81 Down / 0x82 Right / 0x83 Left: ESC [ A / B / C / D.
- 0x84–0x87 PF1–PF4: ESC O P / Q / R / S.
- 0x88–0xFF: accepted, nothing sent.

Reports:
- CPR: ESC [ r ; c R, where r = cursor_x+1 and c = cursor_y+1.
- r and c use 9-bit arithmetic (range 1..256), sent as ASCII decimal with no leading zeros.
- Longest CPR is 10 bytes (ESC [ 2 5 6 ; 2 5 6 R).

Pending requests:
- `reqCpr`/`reqDa` set sticky pending flags in any state.
- A request arriving while the same flag is set merges (only one reply).

FSM states:
- IDLE: select in priority CPR > DA > key.
  - CPR/DA: clear the flag, go to LOAD.
  - Key: only if no flag is pending and `keyValid`; `keyReady`=1 only in IDLE with no flag pending.
  - ASCII and special keys go to LOAD. Ignored codes stay in IDLE.
- LOAD: cursor_x/cursor_y sampled here (not at the request cycle). Bin2Bcd results and bytes are written into a 10-byte buffer with a length register. Go to SEND.
- SEND: `txValid`=1, `txData`=buf[idx]. On transfer, idx++. After the transfer of byte len-1, go to IDLE.

Reset values: txValid=0, txData=0x00, keyReady=0, busy=0, flags clear, idx=0, state IDLE.

## Timing
- Key accepted at cycle N: LOAD at N+1, txValid first high at N+2.
- Same for a request latched at N, when idle.
- txData and txValid are held stable until transferred. txValid never drops without a transfer.
- Back-to-back bytes: one per cycle while txReady=1.
- After the last transfer, txValid=0 in the next cycle (IDLE). The next sequence's first byte comes no earlier than 2 cycles later.
- Simultaneous reqCpr, reqDa and keyValid in IDLE: CPR sent, then DA, then key. The key is held off by keyReady=0.
- A request during SEND does not disturb the current sequence.
- `busy` = (state≠IDLE) | any flag, registered.
- rst asserted mid-sequence: everything is abandoned immediately. No partial resume after release.

## Structure
- Shared package (DataType.sv) holds:
  - `KeyCodeType` constants (KEY_UP…KEY_PF4).
  - `EncoderStateType` enum (IDLE, LOAD, SEND).
  - ASCII constants ESC=0x1B, '[', 'O', ';', '?'.
- Sub-module Bin2Bcd: combinational 9-bit binary to 3 BCD digits (double dabble), instantiated twice (row, column).
- Digit suppression (length 1/2/3) is done in LOAD.

## Test plan
1. Reset, then keyCode=0x61 with txReady=1: txData 0x61 at reset+2, one byte, busy back to 0.
2. keyCode=0x80, txReady toggling 1/0: bytes 0x1B, 0x5B, 0x41 in order; each held while txReady=0.
3. reqCpr with cursor_x=0, cursor_y=0: 1B 5B 31 3B 31 52. With cursor_x=255, cursor_y=9: 1B 5B 32 35 36 3B 31 30 52.
4. reqCpr, reqDa and keyValid (0x84) in the same cycle: CPR, then 1B 5B 3F 31 3B 30 63, then 1B 4F 50. keyReady=0 until both replies are sent.
5. reqCpr pulsed twice during a key sequence: exactly one CPR follows. Cursor values are taken from the LOAD cycle.
6. rst low mid-CPR (after 3 bytes): txValid=0 immediately, flags cleared. After release, no further bytes until a new request.

Source files
------------

// File: rtl/vt100_report_encoder_pkg.sv
// Shared types and constants for the VT100 host-bound report encoder.
package vt100_report_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } encoder_state_t;

  typedef enum logic [1:0] {
    SRC_KEY,
    SRC_CPR,
    SRC_DA
  } source_t;

  localparam logic [7:0] KEY_UP    = 8'h80;
  localparam logic [7:0] KEY_DOWN  = 8'h81;
  localparam logic [7:0] KEY_RIGHT = 8'h82;
  localparam logic [7:0] KEY_LEFT  = 8'h83;
  localparam logic [7:0] KEY_PF1   = 8'h84;
  localparam logic [7:0] KEY_PF2   = 8'h85;
  localparam logic [7:0] KEY_PF3   = 8'h86;
  localparam logic [7:0] KEY_PF4   = 8'h87;

  localparam logic [7:0] ASC_ESC      = 8'h1B;
  localparam logic [7:0] ASC_LBRACKET = 8'h5B;
  localparam logic [7:0] ASC_O        = 8'h4F;
  localparam logic [7:0] ASC_SEMI     = 8'h3B;
  localparam logic [7:0] ASC_QMARK    = 8'h3F;
  localparam logic [7:0] ASC_ZERO     = 8'h30;
  localparam logic [7:0] ASC_ONE      = 8'h31;
  localparam logic [7:0] ASC_R        = 8'h52;
  localparam logic [7:0] ASC_C        = 8'h63;
  localparam logic [7:0] ASC_CUR_BASE = 8'h41;
  localparam logic [7:0] ASC_PF_BASE  = 8'h50;

  localparam int unsigned BUF_LEN = 10;

  // Codes above PF4 are swallowed without producing any bytes.
  function automatic logic key_emits(input logic [7:0] code);
    return code <= KEY_PF4;
  endfunction

  function automatic logic [7:0] bcd_ascii(input logic [3:0] digit);
    return {4'h3, digit};
  endfunction

endpackage

// File: rtl/vt100_report_encoder_if.sv
// Key, report-request and UART-TX signals of the report encoder.
interface vt100_report_encoder_if;
  logic       keyValid;
  logic [7:0] keyCode;
  logic       keyReady;
  logic       reqCpr;
  logic       reqDa;
  logic [7:0] cursor_x;
  logic [7:0] cursor_y;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic       busy;

  modport slave (
    input  keyValid, keyCode, reqCpr, reqDa, cursor_x, cursor_y, txReady,
    output keyReady, txData, txValid, busy
  );

  modport master (
    output keyValid, keyCode, reqCpr, reqDa, cursor_x, cursor_y, txReady,
    input  keyReady, txData, txValid, busy
  );
endinterface

// File: rtl/vt100_report_encoder_bin2bcd.sv
// Combinational 9-bit binary to three BCD digits (double dabble).
module vt100_report_encoder_bin2bcd (
  input  logic [8:0] bin,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [20:0] sr;

  always_comb begin
    sr = {12'd0, bin};
    for (int unsigned i = 0; i < 9; i++) begin
      if (sr[12:9]  >= 4'd5) sr[12:9]  = sr[12:9]  + 4'd3;
      if (sr[16:13] >= 4'd5) sr[16:13] = sr[16:13] + 4'd3;
      if (sr[20:17] >= 4'd5) sr[20:17] = sr[20:17] + 4'd3;
      sr = sr << 1;
    end
    hundreds = sr[20:17];
    tens     = sr[16:13];
    ones     = sr[12:9];
  end

endmodule

// File: rtl/vt100_report_encoder.sv
// Serialises CPR/DA replies and keystrokes into VT100 bytes for the UART TX.
module vt100_report_encoder
  import vt100_report_encoder_pkg::*;
#(
  parameter bit          ENABLE_DA = 1'b1,
  parameter int unsigned DA_OPTION = 0
) (
  input logic                   clk,
  input logic                   rst,
  vt100_report_encoder_if.slave bus
);

  localparam logic [7:0] DA_DIGIT = ASC_ZERO + 8'(DA_OPTION);

  encoder_state_t state_q, state_d;
  source_t        src_q, src_d;
  logic           cpr_pend_q, cpr_pend_d;
  logic           da_pend_q, da_pend_d;
  logic           ready_q, busy_q;
  logic           take_key;
  logic [7:0]     key_q;
  logic [3:0]     len_q, idx_q, idx_d;
  logic [7:0]     buf_q  [BUF_LEN];
  logic [7:0]     ld_buf [BUF_LEN];
  logic [3:0]     ld_len;
  logic [3:0]     pos;

  logic da_req, cpr_any, da_any, key_ready, key_fire;
  logic [8:0] row_bin, col_bin;
  logic [3:0] row_h, row_t, row_o, col_h, col_t, col_o;

  assign da_req  = ENABLE_DA && bus.reqDa;
  assign cpr_any = cpr_pend_q | bus.reqCpr;
  assign da_any  = da_pend_q | da_req;

  // ready_q already implies IDLE with no stored flag; same-cycle requests still win.
  assign key_ready = ready_q & ~bus.reqCpr & ~da_req;
  assign key_fire  = bus.keyValid & key_ready;

  assign bus.keyReady = key_ready;
  assign bus.txValid  = (state_q == SEND);
  assign bus.txData   = (state_q == SEND) ? buf_q[idx_q] : '0;
  assign bus.busy     = busy_q;

  assign row_bin = {1'b0, bus.cursor_x} + 9'd1;
  assign col_bin = {1'b0, bus.cursor_y} + 9'd1;

  vt100_report_encoder_bin2bcd u_row_bcd (
    .bin      (row_bin),
    .hundreds (row_h),
    .tens     (row_t),
    .ones     (row_o)
  );

  vt100_report_encoder_bin2bcd u_col_bcd (
    .bin      (col_bin),
    .hundreds (col_h),
    .tens     (col_t),
    .ones     (col_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    cpr_pend_d = cpr_any;
    da_pend_d  = da_any;
    idx_d      = idx_q;
    take_key   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpr_any) begin
          cpr_pend_d = 1'b0;
          src_d      = SRC_CPR;
          state_d    = LOAD;
        end else if (da_any) begin
          da_pend_d = 1'b0;
          src_d     = SRC_DA;
          state_d   = LOAD;
        end else if (key_fire) begin
          take_key = 1'b1;
          src_d    = SRC_KEY;
          if (key_emits(bus.keyCode)) state_d = LOAD;
        end
      end
      LOAD: begin
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (bus.txReady) begin
          if (idx_q == len_q - 4'd1) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequence builder; the CPR digits drop leading zeros so the tail shifts left.
  always_comb begin
    for (int unsigned i = 0; i < BUF_LEN; i++) ld_buf[i] = '0;
    ld_len = '0;
    pos    = '0;
    case (src_q)
      SRC_KEY: begin
        if (!key_q[7]) begin
          ld_buf[0] = key_q;
          ld_len    = 4'd1;
        end else begin
          ld_buf[0] = ASC_ESC;
          ld_buf[1] = key_q[2] ? ASC_O : ASC_LBRACKET;
          ld_buf[2] = (key_q[2] ? ASC_PF_BASE : ASC_CUR_BASE) + {6'd0, key_q[1:0]};
          ld_len    = 4'd3;
        end
      end
      SRC_DA: begin
        ld_buf[0] = ASC_ESC;
        ld_buf[1] = ASC_LBRACKET;
        ld_buf[2] = ASC_QMARK;
        ld_buf[3] = ASC_ONE;
        ld_buf[4] = ASC_SEMI;
        ld_buf[5] = DA_DIGIT;
        ld_buf[6] = ASC_C;
        ld_len    = 4'd7;
      end
      SRC_CPR: begin
        ld_buf[0] = ASC_ESC;
        ld_buf[1] = ASC_LBRACKET;
        pos       = 4'd2;
        if (row_h != 4'd0) begin
          ld_buf[pos] = bcd_ascii(row_h);
          pos         = pos + 4'd1;
        end
        if (row_h != 4'd0 || row_t != 4'd0) begin
          ld_buf[pos] = bcd_ascii(row_t);
          pos         = pos + 4'd1;
        end
        ld_buf[pos] = bcd_ascii(row_o);
        pos         = pos + 4'd1;
        ld_buf[pos] = ASC_SEMI;
        pos         = pos + 4'd1;
        if (col_h != 4'd0) begin
          ld_buf[pos] = bcd_ascii(col_h);
          pos         = pos + 4'd1;
        end
        if (col_h != 4'd0 || col_t != 4'd0) begin
          ld_buf[pos] = bcd_ascii(col_t);
          pos         = pos + 4'd1;
        end
        ld_buf[pos] = bcd_ascii(col_o);
        pos         = pos + 4'd1;
        ld_buf[pos] = ASC_R;
        pos         = pos + 4'd1;
        ld_len      = pos;
      end
      default: ld_len = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q      <= SRC_KEY;
      key_q      <= '0;
      cpr_pend_q <= 1'b0;
      da_pend_q  <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      idx_q      <= '0;
      len_q      <= '0;
      for (int unsigned i = 0; i < BUF_LEN; i++) buf_q[i] <= '0;
    end else begin
      src_q      <= src_d;
      cpr_pend_q <= cpr_pend_d;
      da_pend_q  <= da_pend_d;
      idx_q      <= idx_d;
      ready_q    <= (state_d == IDLE) & ~cpr_pend_d & ~da_pend_d;
      busy_q     <= (state_d != IDLE) | cpr_pend_d | da_pend_d;
      if (take_key) key_q <= bus.keyCode;
      if (state_q == LOAD) begin
        buf_q <= ld_buf;
        len_q <= ld_len;
      end
    end
  end

endmodule

// File: tb/tb_vt100_report_encoder.sv
// Directed, table-driven bench for vt100_report_encoder.
module tb_vt100_report_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vt100_report_encoder_if bus ();

  vt100_report_encoder #(
    .ENABLE_DA (1'b1),
    .DA_OPTION (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [7:0]  code;
    int          n;
    logic [79:0] val;
    bit          toggle;
  } key_vec_t;

  key_vec_t kv [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drains n bytes (right-aligned in val, first byte most significant).
  task automatic collect(input string name, input logic [79:0] val, input int n, input bit toggle);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [7:0] held = '0;
    logic [7:0] e;
    while (got < n && cyc < 100) begin
      bus.txReady = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (stalled) begin
        check({name, " valid held"}, bus.txValid, 1);
        check({name, " data held"}, bus.txData, held);
      end
      if (bus.txValid) begin
        if (bus.txReady) begin
          e = val[(n-1-got)*8 +: 8];
          check($sformatf("%s byte%0d", name, got), bus.txData, e);
          got++;
          stalled = 0;
        end else begin
          held    = bus.txData;
          stalled = 1;
        end
      end
      step();
      cyc++;
    end
    if (got < n) check({name, " timeout"}, got, n);
    bus.txReady = 1'b1;
    check({name, " valid low after"}, bus.txValid, 0);
  endtask

  task automatic cpr_test(input string name, input logic [7:0] x, input logic [7:0] y,
                          input logic [79:0] val, input int n);
    bus.cursor_x = x;
    bus.cursor_y = y;
    bus.reqCpr   = 1'b1;
    step();
    bus.reqCpr = 1'b0;
    check({name, " load cycle"}, bus.txValid, 0);
    step();
    check({name, " first valid"}, bus.txValid, 1);
    collect(name, val, n, 1'b0);
    check({name, " busy idle"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int cnt;

    kv[0]  = '{8'h61, 1, 80'h61,       1'b0};
    kv[1]  = '{8'h80, 3, 80'h1B5B41,   1'b1};
    kv[2]  = '{8'h00, 1, 80'h00,       1'b0};
    kv[3]  = '{8'h7F, 1, 80'h7F,       1'b1};
    kv[4]  = '{8'h81, 3, 80'h1B5B42,   1'b0};
    kv[5]  = '{8'h82, 3, 80'h1B5B43,   1'b0};
    kv[6]  = '{8'h83, 3, 80'h1B5B44,   1'b1};
    kv[7]  = '{8'h84, 3, 80'h1B4F50,   1'b0};
    kv[8]  = '{8'h87, 3, 80'h1B4F53,   1'b0};
    kv[9]  = '{8'h88, 0, 80'h0,        1'b0};
    kv[10] = '{8'hFF, 0, 80'h0,        1'b0};

    rst          = 1'b0;
    bus.keyValid = 1'b0;
    bus.keyCode  = '0;
    bus.reqCpr   = 1'b0;
    bus.reqDa    = 1'b0;
    bus.cursor_x = '0;
    bus.cursor_y = '0;
    bus.txReady  = 1'b1;
    step();
    step();
    check("reset txValid", bus.txValid, 0);
    check("reset txData", bus.txData, 0);
    check("reset keyReady", bus.keyReady, 0);
    check("reset busy", bus.busy, 0);
    bus.keyValid = 1'b1;
    bus.keyCode  = 8'h61;
    #1;
    check("reset keyReady with key", bus.keyReady, 0);
    step();
    rst = 1'b1;

    // Keystroke table: first entry is the post-reset 0x61 case.
    for (int i = 0; i < 11; i++) begin
      bus.keyCode  = kv[i].code;
      bus.keyValid = 1'b1;
      k = 0;
      while (!bus.keyReady && k < 20) begin
        step();
        k++;
      end
      check($sformatf("key%0d accept", i), bus.keyReady, 1);
      step();
      bus.keyValid = 1'b0;
      check($sformatf("key%0d load cycle", i), bus.txValid, 0);
      if (kv[i].n == 0) begin
        step();
        step();
        check($sformatf("key%0d ignored", i), bus.txValid, 0);
      end else begin
        step();
        check($sformatf("key%0d first valid", i), bus.txValid, 1);
        collect($sformatf("key%0d", i), kv[i].val, kv[i].n, kv[i].toggle);
      end
      check($sformatf("key%0d busy", i), bus.busy, 0);
    end

    cpr_test("cpr 0,0",     8'd0,   8'd0,  80'h1B5B313B3152, 6);
    cpr_test("cpr 255,9",   8'd255, 8'd9,  80'h1B5B3235363B313052, 9);
    cpr_test("cpr 99,99",   8'd99,  8'd99, 80'h1B5B3130303B31303052, 10);
    cpr_test("cpr 8,98",    8'd8,   8'd98, 80'h1B5B393B393952, 7);

    // CPR, DA and key offered together.
    bus.cursor_x = 8'd4;
    bus.cursor_y = 8'd6;
    bus.reqCpr   = 1'b1;
    bus.reqDa    = 1'b1;
    bus.keyValid = 1'b1;
    bus.keyCode  = 8'h84;
    #1;
    check("prio keyReady blocked", bus.keyReady, 0);
    step();
    bus.reqCpr = 1'b0;
    bus.reqDa  = 1'b0;
    check("prio cpr load", bus.txValid, 0);
    check("prio busy", bus.busy, 1);
    step();
    collect("prio cpr", 80'h1B5B353B3752, 6, 1'b0);
    check("prio keyReady after cpr", bus.keyReady, 0);
    step();
    check("prio da load", bus.txValid, 0);
    check("prio keyReady da load", bus.keyReady, 0);
    step();
    collect("prio da", 80'h1B5B3F313B3063, 7, 1'b0);
    check("prio keyReady after da", bus.keyReady, 1);
    step();
    bus.keyValid = 1'b0;
    check("prio key load", bus.txValid, 0);
    step();
    collect("prio key", 80'h1B4F50, 3, 1'b0);
    check("prio busy end", bus.busy, 0);

    // Two CPR pulses during a key; cursor changes before LOAD.
    bus.cursor_x = 8'd1;
    bus.cursor_y = 8'd1;
    bus.keyCode  = 8'h41;
    bus.keyValid = 1'b1;
    #1;
    check("merge accept", bus.keyReady, 1);
    step();
    bus.keyValid = 1'b0;
    bus.txReady  = 1'b0;
    step();
    check("merge key valid", bus.txValid, 1);
    check("merge key data", bus.txData, 8'h41);
    bus.reqCpr = 1'b1;
    step();
    bus.reqCpr = 1'b0;
    check("merge key held", bus.txData, 8'h41);
    step();
    bus.reqCpr = 1'b1;
    step();
    bus.reqCpr  = 1'b0;
    bus.txReady = 1'b1;
    check("merge key still valid", bus.txValid, 1);
    check("merge key still data", bus.txData, 8'h41);
    step();
    check("merge idle gap", bus.txValid, 0);
    check("merge busy pending", bus.busy, 1);
    bus.cursor_x = 8'd20;
    bus.cursor_y = 8'd30;
    step();
    check("merge cpr load", bus.txValid, 0);
    step();
    collect("merge cpr", 80'h1B5B32313B333152, 8, 1'b0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.txValid) cnt++;
      step();
    end
    check("merge single reply", cnt, 0);
    check("merge busy end", bus.busy, 0);

    // Reset in the middle of a CPR with a DA pending.
    bus.cursor_x = 8'd255;
    bus.cursor_y = 8'd255;
    bus.reqCpr   = 1'b1;
    step();
    bus.reqCpr = 1'b0;
    step();
    check("abort byte0", bus.txData, 8'h1B);
    step();
    check("abort byte1", bus.txData, 8'h5B);
    bus.reqDa = 1'b1;
    step();
    bus.reqDa = 1'b0;
    check("abort byte2", bus.txData, 8'h32);
    step();
    check("abort byte3 valid", bus.txValid, 1);
    rst = 1'b0;
    #1;
    check("abort txValid", bus.txValid, 0);
    check("abort busy", bus.busy, 0);
    check("abort keyReady", bus.keyReady, 0);
    step();
    step();
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.txValid) cnt++;
      step();
    end
    check("abort no resume", cnt, 0);
    check("abort busy after", bus.busy, 0);
    cpr_test("recover cpr", 8'd0, 8'd0, 80'h1B5B313B3152, 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
